// File: rtl/ni_tx_arbiter_pkg.sv
// ============================================================================
// ni_tx_arbiter_pkg : flit/packet types, TX state encoding and flit selector
// Revision: 1.0
// ============================================================================
`default_nettype none

package ni_tx_arbiter_pkg;

  localparam int NI_FLIT_W          = 16;
  localparam int NI_NUM_BODY_FLITS  = 3;
  localparam int NI_TOTAL_FLITS     = NI_NUM_BODY_FLITS + 2;

  typedef logic [NI_FLIT_W-1:0] flit_t;

  typedef struct packed {
    logic [1:0] ftype;
    logic [3:0] dst;
    logic [3:0] src;
    logic [5:0] tag;
  } head_flit_s;

  typedef struct packed {
    head_flit_s                         head;
    flit_t [NI_NUM_BODY_FLITS-1:0]      body;
    flit_t                              tail;
  } req_packet_s;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } ni_tx_state_e;

  // Flit idx of a packet: 0 = head, 1..NUM_BODY = body[idx-1], otherwise tail.
  function automatic flit_t pkt_flit(req_packet_s p, int idx);
    flit_t f;
    f = p.tail;
    if (idx == 0) f = flit_t'(p.head);
    for (int b = 0; b < NI_NUM_BODY_FLITS; b++) begin
      if (idx == b + 1) f = p.body[b];
    end
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ni_rr_arbiter.sv
// ============================================================================
// ni_rr_arbiter : combinational round-robin picker starting at i_ptr
// Revision: 1.0
// ============================================================================
`default_nettype none

module ni_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_id,
  output logic          o_any
);

  always_comb begin
    o_gnt    = '0;
    o_gnt_id = '0;
    o_any    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_en && !o_any && i_req[(int'(i_ptr) + i) % N]) begin
        o_any                          = 1'b1;
        o_gnt[(int'(i_ptr) + i) % N]   = 1'b1;
        o_gnt_id                       = IW'((int'(i_ptr) + i) % N);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ni_tx_arbiter.sv
// ============================================================================
// ni_tx_arbiter : round-robin packet arbiter serialising head/body/tail flits
// Revision: 1.0
// ============================================================================
`default_nettype none

module ni_tx_arbiter
  import ni_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int FLIT_W      = NI_FLIT_W,
  parameter int TOTAL_FLITS = NI_TOTAL_FLITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  req_packet_s [NUM_REQ-1:0]  req_packet,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [FLIT_W-1:0]          flit_out,
  output logic                       flit_valid,
  input  logic                       flit_ready,
  output logic                       flit_is_head,
  output logic                       flit_is_tail,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TOTAL_FLITS);
  localparam logic [CW-1:0] c_last_flit = CW'(TOTAL_FLITS - 1);

  ni_tx_state_e        r_state;
  logic [IDW-1:0]      r_rr_ptr;
  logic [IDW-1:0]      r_grant_id;
  logic [CW-1:0]       r_flit_cnt;
  req_packet_s         r_pkt_buf;

  logic                w_send;
  logic                w_tail_acc;
  logic                w_arb_en;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [IDW-1:0]      w_gnt_id;
  logic                w_any;

  assign w_send     = (r_state == TX_SEND);
  assign w_tail_acc = w_send && flit_ready && (r_flit_cnt == c_last_flit);
  // Gated by rst_n so req_ready reads 0 while reset is held.
  assign w_arb_en   = rst_n && (!w_send || w_tail_acc);

  ni_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_rr_arbiter (
    .i_req    (req_valid),
    .i_ptr    (r_rr_ptr),
    .i_en     (w_arb_en),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id),
    .o_any    (w_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= TX_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_flit_cnt <= '0;
      r_pkt_buf  <= '0;
    end else if (w_any) begin
      r_state    <= TX_SEND;
      r_pkt_buf  <= req_packet[w_gnt_id];
      r_grant_id <= w_gnt_id;
      r_rr_ptr   <= (w_gnt_id == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
      r_flit_cnt <= '0;
    end else if (w_tail_acc) begin
      r_state    <= TX_IDLE;
      r_flit_cnt <= '0;
    end else if (w_send && flit_ready) begin
      r_flit_cnt <= r_flit_cnt + 1'b1;
    end
  end

  assign req_ready    = w_gnt;
  assign flit_valid   = w_send;
  assign busy         = w_send;
  assign grant_id     = r_grant_id;
  assign flit_out     = w_send ? FLIT_W'(pkt_flit(r_pkt_buf, int'(r_flit_cnt))) : '0;
  assign flit_is_head = w_send && (r_flit_cnt == '0);
  assign flit_is_tail = w_send && (r_flit_cnt == c_last_flit);

endmodule

`default_nettype wire

// File: tb/tb_ni_tx_arbiter.sv
// ============================================================================
// tb_ni_tx_arbiter : directed + randomized bench with a packet-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ni_tx_arbiter;
  import ni_tx_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int TF = NI_TOTAL_FLITS;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NR-1:0]          req_valid;
  req_packet_s [NR-1:0]   req_packet;
  logic [NR-1:0]          req_ready;
  logic [NI_FLIT_W-1:0]   flit_out;
  logic                   flit_valid;
  logic                   flit_ready;
  logic                   flit_is_head;
  logic                   flit_is_tail;
  logic [1:0]             grant_id;
  logic                   busy;

  ni_tx_arbiter #(.NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_packet(req_packet),
    .req_ready(req_ready), .flit_out(flit_out), .flit_valid(flit_valid),
    .flit_ready(flit_ready), .flit_is_head(flit_is_head), .flit_is_tail(flit_is_tail),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Packet-level reference: captured flit list, position, rotation pointer.
  flit_t m_pkt[TF];
  int    m_idx = 0;
  int    m_rr  = 0;
  int    m_gid = 0;
  bit    m_busy = 0;
  int    g_log[$];
  bit    auto_drop = 1;

  flit_t last_flit;
  logic  last_valid, last_head, last_tail;

  function automatic int winner();
    for (int k = 0; k < NR; k++)
      if (req_valid[(m_rr + k) % NR]) return (m_rr + k) % NR;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_idx = 0; m_rr = 0; m_gid = 0;
  endtask

  task automatic step();
    int w;
    int hs;
    bit en;
    logic [NR-1:0] er;
    hs = -1;
    @(negedge clk);
    last_flit = flit_out; last_valid = flit_valid;
    last_head = flit_is_head; last_tail = flit_is_tail;
    if (!rst_n) begin
      check("rst_valid", flit_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", req_ready, 0);
      model_reset();
    end else begin
      en = !m_busy || (flit_ready && m_idx == TF - 1);
      w  = winner();
      er = '0;
      if (en && w >= 0) er[w] = 1'b1;
      check("req_ready", req_ready, er);
      check("flit_valid", flit_valid, m_busy);
      check("busy", busy, m_busy);
      if (m_busy) begin
        check("flit_out", flit_out, m_pkt[m_idx]);
        check("is_head", flit_is_head, m_idx == 0);
        check("is_tail", flit_is_tail, m_idx == TF - 1);
        check("grant_id", grant_id, m_gid);
      end
      if (en && w >= 0) begin
        m_pkt[0] = req_packet[w].head;
        for (int b = 0; b < TF - 2; b++) m_pkt[b+1] = req_packet[w].body[b];
        m_pkt[TF-1] = req_packet[w].tail;
        m_gid = w; m_rr = (w + 1) % NR; m_idx = 0; m_busy = 1;
        g_log.push_back(w);
        hs = w;
      end else if (m_busy && flit_ready) begin
        if (m_idx == TF - 1) begin m_busy = 0; m_idx = 0; end
        else m_idx++;
      end
    end
    @(posedge clk); #1;
    if (hs >= 0 && auto_drop) req_valid[hs] = 1'b0;
  endtask

  task automatic set_pkt(input int s, input flit_t h, input flit_t b0, input flit_t b1,
                         input flit_t b2, input flit_t t);
    req_packet[s].head    = head_flit_s'(h);
    req_packet[s].body[0] = b0;
    req_packet[s].body[1] = b1;
    req_packet[s].body[2] = b2;
    req_packet[s].tail    = t;
  endtask

  task automatic rand_pkt(input int s);
    set_pkt(s, flit_t'($urandom), flit_t'($urandom), flit_t'($urandom),
            flit_t'($urandom), flit_t'($urandom));
  endtask

  task automatic check_grant(input string tag, input int exp);
    int g;
    g = (g_log.size() > 0) ? g_log.pop_front() : 99;
    check(tag, g, exp);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (m_busy || req_valid != '0); k++) step();
    check("drain_idle", m_busy || (req_valid != '0), 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  flit_t t1_exp[TF] = '{16'hA123, 16'h1111, 16'h2222, 16'h3333, 16'h4444};

  initial begin
    rst_n = 1'b0; req_valid = '0; req_packet = '0; flit_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step();

    // Single source, fixed packet
    g_log.delete();
    set_pkt(1, 16'hA123, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    req_valid[1] = 1'b1;
    step();
    for (int i = 0; i < TF; i++) begin
      step();
      check("t1_flit", last_flit, t1_exp[i]);
      check("t1_head", last_head, i == 0);
      check("t1_tail", last_tail, i == TF - 1);
    end
    check_grant("t1_grant", 1);
    drain();

    // Two sources from reset, no-bubble handoff, then rotation resumes at 0
    pulse_reset();
    g_log.delete();
    rand_pkt(0); rand_pkt(2);
    req_valid = 4'b0101;
    drain();
    check_grant("t2_first", 0);
    check_grant("t2_second", 2);
    rand_pkt(0); rand_pkt(2);
    req_valid = 4'b0101;
    drain();
    check_grant("t2_again", 0);
    check_grant("t2_again2", 2);

    // Backpressure on body1
    set_pkt(1, 16'hA123, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    req_valid[1] = 1'b1;
    for (int k = 0; k < 20 && !(m_busy && m_idx == 2); k++) step();
    check("t3_reach_body1", m_busy && m_idx == 2, 1);
    flit_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t3_hold_flit", last_flit, 16'h2222);
      check("t3_hold_valid", last_valid, 1);
    end
    flit_ready = 1'b1;
    step(); check("t3_resume_b1", last_flit, 16'h2222);
    step(); check("t3_resume_b2", last_flit, 16'h3333);
    step(); check("t3_resume_tail", last_flit, 16'h4444);
    drain();

    // All sources continuously valid: 8 packets back to back
    pulse_reset();
    g_log.delete();
    auto_drop = 0;
    for (int s = 0; s < NR; s++) rand_pkt(s);
    req_valid = '1;
    step();
    for (int c = 0; c < 8 * TF; c++) begin
      if (c == 8 * TF - 1) req_valid = '0;
      step();
      check("t4_valid", last_valid, 1);
    end
    auto_drop = 1;
    for (int g = 0; g < 8; g++) check_grant("t4_order", g % NR);
    drain();

    // Reset during flit 2
    rand_pkt(0);
    req_valid[0] = 1'b1;
    for (int k = 0; k < 20 && !(m_busy && m_idx == 2); k++) step();
    check("t5_reach", m_busy && m_idx == 2, 1);
    req_valid[0] = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t5_valid", flit_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_ready", req_ready, 0);
    model_reset();
    step();
    req_valid = 4'b1010;
    rand_pkt(1); rand_pkt(3);
    g_log.delete();
    rst_n = 1'b1;
    drain();
    check_grant("t5_first", 1);
    check_grant("t5_second", 3);

    // Source changes after capture do not reach the link
    set_pkt(0, 16'h5A5A, 16'h0001, 16'h0002, 16'h0003, 16'hC0DE);
    req_valid[0] = 1'b1;
    step();
    rand_pkt(0);
    for (int i = 0; i < TF; i++) step();
    check("t6_tail", last_flit, 16'hC0DE);
    drain();

    // Randomized traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      flit_ready = ($urandom_range(0, 3) != 0);
      for (int s = 0; s < NR; s++)
        if (!req_valid[s] && $urandom_range(0, 3) == 0) begin
          rand_pkt(s);
          req_valid[s] = 1'b1;
        end
      step();
    end
    flit_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
